// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the mem_bus_master requester port toward memory_top.
package mem_bus_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 12;
    localparam int unsigned TMO_CYCLES_DEF = 255;

    typedef enum logic [2:0] {
        ST_RST_WAIT = 3'd0,
        ST_IDLE     = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT     = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // States in which the master is blocked on mem_busy
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_RST_WAIT) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/mem_bus_watchdog.sv
// Busy-timeout watchdog: counts consecutive busy cycles and raises a sticky error flag.
// Only present when MEM_BUS_TIMEOUT_EN is defined.
`ifdef MEM_BUS_TIMEOUT_EN
module mem_bus_watchdog #(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic busy_wait,
    output logic expire_c,
    output logic err_timeout
);

    localparam int unsigned CNT_W = $clog2(TMO_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // Fires on the TMO_CYCLES-th consecutive busy cycle
    assign expire_c = busy_wait && (cnt == CNT_W'(TMO_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (!busy_wait || expire_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (expire_c) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/mem_bus_master.sv
// Requester-side master for memory_top: single-beat read/write with busy handshake.
// Optional busy timeout watchdog enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_rd_enable,
    output logic                  mem_wr_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_busy,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  err_timeout
);

    state_t state;
    logic   we_q;
    logic   wait_busy_c;
    logic   expire_c;

    assign req_ready   = (state == ST_IDLE) && !mem_busy;
    assign wait_busy_c = is_wait_state(state) && mem_busy;

`ifdef MEM_BUS_TIMEOUT_EN
    mem_bus_watchdog #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .busy_wait   (wait_busy_c),
        .expire_c    (expire_c),
        .err_timeout (err_timeout)
    );
`else
    logic unused_cfg;
    assign expire_c    = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_cfg  = ^{32'(TMO_CYCLES), wait_busy_c};
`endif

    // Request sequencer: accept -> one enable pulse -> wait on busy -> one response pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_RST_WAIT;
            we_q          <= 1'b0;
            mem_rd_enable <= 1'b0;
            mem_wr_enable <= 1'b0;
            mem_addr      <= '0;
            mem_wr_data   <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
        end else begin
            mem_rd_enable <= 1'b0;
            mem_wr_enable <= 1'b0;
            resp_valid    <= 1'b0;
            case (state)
                ST_RST_WAIT: begin
                    if (!mem_busy || expire_c) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q          <= req_we;
                        mem_addr      <= req_addr;
                        mem_wr_data   <= req_wdata;
                        mem_rd_enable <= !req_we;
                        mem_wr_enable <= req_we;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A forced timeout exit returns zero data
                    if (!mem_busy || expire_c) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= (we_q || mem_busy) ? '0 : mem_rd_data;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_RST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: memory emulator, transaction-level model, directed + random traffic.
module tb_mem_bus_master;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 12;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          mem_rd_enable;
    logic          mem_wr_enable;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_busy;
    logic [DW-1:0] mem_rd_data;
    logic          err_timeout;

    mem_bus_master #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .mem_rd_enable (mem_rd_enable),
        .mem_wr_enable (mem_wr_enable),
        .mem_addr      (mem_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_busy      (mem_busy),
        .mem_rd_data   (mem_rd_data),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model of what the requester should observe
    bit            rst_hold  = 1'b1;
    bit            txn_open  = 1'b0;
    bit            resp_now  = 1'b0;
    bit            post_rst  = 1'b0;
    bit            exp_err   = 1'b0;
    int            age       = 0;
    bit            t_we      = 1'b0;
    logic [AW-1:0] t_addr    = '0;
    logic [DW-1:0] t_wdata   = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] ref_mem [4096];
`ifdef MEM_BUS_TIMEOUT_EN
    int            tmo_cnt   = 0;
`endif

    // Memory emulator state
    logic [DW-1:0] emu_mem [4096];
    int            busy_left  = 0;
    int            force_busy = 0;
    int            fix_b      = 0;
    bit            stuck      = 1'b0;
    bit            idle_rand  = 1'b0;
    bit            rd_pend    = 1'b0;
    logic [AW-1:0] rd_addr    = '0;
    logic          nxt_busy   = 1'b1;
    logic [DW-1:0] nxt_rdata  = '0;

    function automatic int pick_busy();
        return (fix_b >= 0) ? fix_b : int'($urandom_range(0, 3));
    endfunction

    always @(posedge clk) begin
        #1;
        mem_busy    = nxt_busy;
        mem_rd_data = nxt_rdata;
    end

    always @(negedge clk) begin
        logic exp_ready;
        bit   tmo_fire;
`ifdef MEM_BUS_TIMEOUT_EN
        bit   in_wait;
`endif
        exp_ready = !rst_hold && !txn_open && !mem_busy;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rd_enable", 32'(mem_rd_enable), 32'(txn_open && age == 1 && !t_we));
        chk("wr_enable", 32'(mem_wr_enable), 32'(txn_open && age == 1 && t_we));
        chk("resp_valid", 32'(resp_valid), 32'(resp_now));
        if (resp_now) chk("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
        if (txn_open && !resp_now) begin
            chk("mem_addr", 32'(mem_addr), 32'(t_addr));
            if (t_we) chk("mem_wr_data", 32'(mem_wr_data), 32'(t_wdata));
        end
        chk("err_timeout", 32'(err_timeout), 32'(exp_err));
        if (post_rst) begin
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wr_data", 32'(mem_wr_data), 32'd0);
            chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        end

        tmo_fire = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
        in_wait = rst_hold || (txn_open && age >= 2 && !resp_now);
        if (reset && in_wait && mem_busy) tmo_cnt++;
        else tmo_cnt = 0;
        if (tmo_cnt == int'(TMO)) begin
            tmo_fire = 1'b1;
            tmo_cnt  = 0;
        end
`endif

        post_rst = 1'b0;
        if (!reset) begin
            rst_hold = 1'b1;
            txn_open = 1'b0;
            resp_now = 1'b0;
            post_rst = 1'b1;
            exp_err  = 1'b0;
        end else if (resp_now) begin
            resp_now = 1'b0;
            txn_open = 1'b0;
        end else if (txn_open) begin
            if (age >= 2 && (!mem_busy || tmo_fire)) begin
                resp_now = 1'b1;
                if (mem_busy) exp_rdata = '0;
            end
            age++;
            if (tmo_fire) exp_err = 1'b1;
        end else if (rst_hold) begin
            if (!mem_busy || tmo_fire) rst_hold = 1'b0;
            if (tmo_fire) exp_err = 1'b1;
        end else if (req_valid && exp_ready) begin
            t_we     = req_we;
            t_addr   = req_addr;
            t_wdata  = req_wdata;
            txn_open = 1'b1;
            age      = 1;
            if (req_we) begin
                ref_mem[req_addr] = req_wdata;
                exp_rdata         = '0;
            end else begin
                exp_rdata = ref_mem[req_addr];
            end
        end

        // Memory emulator: plays memory_top for the next cycle
        nxt_rdata = DW'($urandom);
        if (!reset) begin
            busy_left = 0;
            rd_pend   = 1'b0;
            nxt_busy  = 1'b1;
        end else begin
            if (mem_wr_enable) begin
                emu_mem[mem_addr] = mem_wr_data;
                busy_left         = pick_busy();
            end
            if (mem_rd_enable) begin
                rd_pend   = 1'b1;
                rd_addr   = mem_addr;
                busy_left = pick_busy();
            end
            if (stuck || force_busy > 0) begin
                nxt_busy = 1'b1;
                if (force_busy > 0) force_busy--;
            end else if (busy_left > 0) begin
                nxt_busy = 1'b1;
                busy_left--;
            end else if (rd_pend) begin
                nxt_busy  = 1'b0;
                nxt_rdata = emu_mem[rd_addr];
                rd_pend   = 1'b0;
            end else begin
                nxt_busy = idle_rand && ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        output int acc);
        int n;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_wait", 32'(req_ready), 32'd1);
                break;
            end
        end
        acc = cyc;
    endtask

    task automatic drop();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int acc, output int lat, output logic [DW-1:0] rd);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (resp_valid) break;
            n++;
            if (n > 300) begin
                chk("resp_wait", 32'(resp_valid), 32'd1);
                break;
            end
        end
        lat = cyc - acc;
        rd  = resp_rdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int            a1;
        int            a2;
        int            lat;
        int            n;
        logic [DW-1:0] rd;
        logic          r_we;
        logic [AW-1:0] r_addr;

        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = DW'($urandom);
            emu_mem[i] = ref_mem[i];
        end
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        mem_busy    = 1'b1;
        mem_rd_data = '0;
        idle_rand   = 1'b0;
        fix_b       = 0;
        force_busy  = 4;

        // Reset held 10 cycles, then memory busy for 5 more
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rd_enable", 32'(mem_rd_enable), 32'd0);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("init_ready_low", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        chk("init_ready_high", 32'(req_ready), 32'd1);

        // Write 0x123 <= 0xA5 with two busy cycles
        fix_b = 2;
        send(1'b1, 12'h123, 8'hA5, a1);
        drop();
        wait_resp(a1, lat, rd);
        chk("wr_latency", 32'(lat), 32'd5);
        chk("wr_rdata", 32'(rd), 32'd0);

        send(1'b0, 12'h123, 8'h00, a1);
        drop();
        wait_resp(a1, lat, rd);
        chk("rd_latency", 32'(lat), 32'd5);
        chk("rd_rdata", 32'(rd), 32'hA5);

        fix_b = 0;
        send(1'b0, 12'h123, 8'h00, a1);
        drop();
        wait_resp(a1, lat, rd);
        chk("rd_min_latency", 32'(lat), 32'd3);
        chk("rd_min_rdata", 32'(rd), 32'hA5);

        // Back-to-back reads of both address extremes with req_valid held
        send(1'b1, 12'h000, 8'h3C, a1);
        send(1'b1, 12'hFFF, 8'hC3, a2);
        drop();
        wait_resp(a2, lat, rd);
        send(1'b0, 12'h000, 8'h00, a1);
        send(1'b0, 12'hFFF, 8'h00, a2);
        drop();
        wait_resp(a2, lat, rd);
        chk("b2b_spacing", 32'(a2 - a1), 32'd4);
        chk("b2b_rdata", 32'(rd), 32'hC3);

        // Reset during the wait phase of a read
        fix_b = 6;
        send(1'b0, 12'h123, 8'h00, a1);
        drop();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_rd_enable", 32'(mem_rd_enable), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        fix_b = 0;
        send(1'b0, 12'h123, 8'h00, a1);
        drop();
        wait_resp(a1, lat, rd);
        chk("restart_rdata", 32'(rd), 32'hA5);

        // Randomised traffic with random busy and occasional idle gaps
        fix_b     = -1;
        idle_rand = 1'b1;
        for (int i = 0; i < 250; i++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            send(r_we, r_addr, DW'($urandom), a1);
            if ($urandom_range(0, 2) == 0) begin
                drop();
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end
        drop();
        n = 0;
        while (txn_open && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(dut.req_ready || txn_open), 32'(!txn_open && !mem_busy));

`ifdef MEM_BUS_TIMEOUT_EN
        // Busy stuck after issue: forced exit after TMO busy cycles
        idle_rand = 1'b0;
        fix_b     = 0;
        repeat (4) @(posedge clk);
        send(1'b0, 12'h123, 8'h00, a1);
        stuck = 1'b1;
        drop();
        wait_resp(a1, lat, rd);
        chk("tmo_latency", 32'(lat), 32'(TMO + 2));
        chk("tmo_rdata", 32'(rd), 32'd0);
        chk("tmo_err_set", 32'(err_timeout), 32'd1);
        stuck = 1'b0;
        repeat (5) @(negedge clk);
        chk("tmo_err_sticky", 32'(err_timeout), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("tmo_err_cleared", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
